mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage MIPS pipeline, placed directly downstream of the execute stage. It registers the execute outputs (ALU result, store data, destination register, control bits) into the EX/MEM register and runs the load/store handshake with data memory. It then writes the MEM/WB register for write-back. It stalls the upstream pipeline while a memory access is outstanding, and drives the EX/MEM and MEM/WB forwarding operands consumed by the execute-stage forwarding muxes.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: the execute stage holds a real instruction.
- `ex_result` in 32: ALU result; this is the memory address for loads and stores.
- `ex_store_data` in 32: forwarded second operand, used as store data.
- `ex_reg_dest` in 5: destination register selected in execute.
- `ex_signals` in 4: control bits {RegWrite, MemToReg, MemWrite, MemRead}, with bit 3 = RegWrite.
- `flush` in 1: discard the instruction arriving from execute.
- `stall` out 1: upstream must hold its state and `ex_*` stable.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 32: memory address.
- `dmem_wdata` out 32: store data.
- `dmem_rdata` in 32: load data, valid when `dmem_ack` = 1.
- `dmem_ack` in 1: request completed this cycle.
- `EX_MEM_op` out 32: EX/MEM ALU result, used for forwarding.
- `EX_MEM_reg_dest` out 5: EX/MEM destination register.
- `EX_MEM_RegWrite` out 1: EX/MEM RegWrite, qualified by valid.
- `MEM_WB_op` out 32: MEM/WB write-back data, used for forwarding and write-back.
- `MEM_WB_reg_dest` out 5: MEM/WB destination register.
- `MEM_WB_RegWrite` out 1: MEM/WB RegWrite, qualified by valid.
- `misaligned` out 1: pulse marking a misaligned access. Exists only when `MEM_ALIGN_CHECK_EN` is defined.

## Operation
The FSM has two states, IDLE and WAIT.

EX/MEM capture:
- Each edge where `stall` = 0, EX/MEM loads `{ex_valid & ~flush, ex_result, ex_store_data, ex_reg_dest, ex_signals}`.
- A flushed or invalid entry is a bubble: its control bits are forced to 0.
- `flush` is ignored while `stall` = 1, so an in-flight access always completes.

IDLE:
- If the captured EX/MEM entry is valid and has MemRead or MemWrite set, the next state is WAIT.
- Otherwise the entry passes to MEM/WB at the next edge and the FSM stays in IDLE.

WAIT:
- `dmem_req` = 1, `dmem_we` = MemWrite, `dmem_addr` = EX/MEM result, `dmem_wdata` = EX/MEM store data.
- These four outputs stay constant until `dmem_ack` is sampled high.
- On an edge with `dmem_ack` = 1:
  - MEM/WB loads the entry. For a load, `MEM_WB_op` = `dmem_rdata` when MemToReg = 1, otherwise the ALU result.
  - The FSM returns to IDLE and EX/MEM captures the next instruction on the same edge.
- On an edge with `dmem_ack` = 0: MEM/WB loads a bubble (RegWrite = 0).

Signal rules:
- `stall` = (state == WAIT) & ~`dmem_ack`. This is combinational.
- `dmem_ack` is ignored while in IDLE.
- MemRead and MemWrite both set: treated as a write.
- Every instruction is written to MEM/WB exactly once.
- The `EX_MEM_*` and `MEM_WB_*` outputs are direct register outputs. RegWrite outputs are 0 for bubbles.

## Timing
- Reset values (all registers): state IDLE, `stall` 0, `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0, every `EX_MEM_*` and `MEM_WB_*` output 0, `misaligned` 0.
- Latency for a non-memory instruction: captured at edge E0, MEM/WB valid after edge E1.
- Latency for a load or store: captured at E0, `dmem_req` high after E0. If `dmem_ack` is first high in the cycle ending at edge E0+k (k ≥ 1), MEM/WB is valid after E0+k and `stall` is high for k−1 cycles.
- Back-to-back loads with zero-wait memory (ack in the first request cycle) sustain 1 instruction per cycle.
- `rst` during WAIT: `dmem_req` is 0 after the reset edge. The pending access is abandoned and a late `dmem_ack` is ignored.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - A memory entry with `ex_result[1:0]` ≠ 0 does not enter WAIT and no request is issued.
  - It passes to MEM/WB with RegWrite forced to 0.
  - `misaligned` pulses high for the one cycle after that MEM/WB update.
- Undefined:
  - No check is performed and the `misaligned` port is absent.
  - Addresses are issued unmodified, including the low two bits.

## Test plan
- ALU op, no memory bits, `ex_result` = 0x0000_0010, `ex_reg_dest` = 5, RegWrite = 1 → `EX_MEM_op` = 0x10 after E0; `MEM_WB_op` = 0x10, `MEM_WB_reg_dest` = 5, `MEM_WB_RegWrite` = 1 after E1; `stall` stays 0.
- Load at address 0x100, ack after 3 request cycles, `dmem_rdata` = 0xDEAD_BEEF → `dmem_req` held 3 cycles with address 0x100 and `dmem_we` = 0; `stall` high 2 cycles; `MEM_WB_op` = 0xDEAD_BEEF; exactly one MEM/WB write.
- Store at address 0x200 with data 0x1234_5678, ack in the first request cycle → `dmem_we` = 1, `dmem_wdata` = 0x1234_5678; `stall` never high; `MEM_WB_RegWrite` = 0.
- `flush` = 1 with a valid load at the input → no `dmem_req`; MEM/WB receives a bubble.
- `flush` asserted while in WAIT → ignored; the load completes normally.
- `rst` in the 2nd cycle of WAIT, then `dmem_ack` = 1 → all outputs are at their reset values; no MEM/WB write.
- With `MEM_ALIGN_CHECK_EN` defined, load at address 0x102 → no request; `misaligned` pulses for 1 cycle; `MEM_WB_RegWrite` = 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM capture, data-memory handshake, MEM/WB update. Build option MEM_ALIGN_CHECK_EN.
// Latency: 1 edge to MEM/WB (non-memory), k edges after capture for memory ops; stall while waiting on dmem_ack.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_reg_dest,
    input  logic [3:0]  ex_signals,
    input  logic        flush,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] EX_MEM_op,
    output logic [4:0]  EX_MEM_reg_dest,
    output logic        EX_MEM_RegWrite,
    output logic [31:0] MEM_WB_op,
    output logic [4:0]  MEM_WB_reg_dest,
    output logic        MEM_WB_RegWrite
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    localparam int SIG_RW  = 3;
    localparam int SIG_M2R = 2;
    localparam int SIG_MW  = 1;
    localparam int SIG_MR  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] em_result_q, em_result_d;
    logic [31:0] em_sdata_q, em_sdata_d;
    logic [4:0]  em_dest_q, em_dest_d;
    logic [3:0]  em_sig_q, em_sig_d;
    logic [31:0] mw_op_q, mw_op_d;
    logic [4:0]  mw_dest_q, mw_dest_d;
    logic        mw_rw_q, mw_rw_d;

    logic        in_vld;
    logic        in_mem;
    logic        em_mis;

`ifdef MEM_ALIGN_CHECK_EN
    logic        mis_q, mis_d;
    // A misaligned memory entry never issues; it drains through IDLE like an ALU op.
    assign em_mis = (em_sig_q[SIG_MW] | em_sig_q[SIG_MR]) & (em_result_q[1:0] != 2'b00);
    assign in_mem = in_vld & (ex_signals[SIG_MW] | ex_signals[SIG_MR])
                    & (ex_result[1:0] == 2'b00);
    assign misaligned = mis_q;
`else
    assign em_mis = 1'b0;
    assign in_mem = in_vld & (ex_signals[SIG_MW] | ex_signals[SIG_MR]);
`endif

    assign in_vld = ex_valid & ~flush;

    always_comb begin
        state_d     = state_q;
        em_result_d = em_result_q;
        em_sdata_d  = em_sdata_q;
        em_dest_d   = em_dest_q;
        em_sig_d    = em_sig_q;
        mw_op_d     = mw_op_q;
        mw_dest_d   = mw_dest_q;
        mw_rw_d     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis_d       = 1'b0;
`endif
        stall       = (state_q == ST_WAIT) & ~dmem_ack;

        case (state_q)
            ST_IDLE: begin
                mw_op_d   = em_result_q;
                mw_dest_d = em_dest_q;
                mw_rw_d   = em_sig_q[SIG_RW] & ~em_mis;
`ifdef MEM_ALIGN_CHECK_EN
                mis_d     = em_mis;
`endif
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    // Read-and-write combinations behave as stores, so no load data is returned.
                    mw_op_d   = (em_sig_q[SIG_M2R] & ~em_sig_q[SIG_MW]) ? dmem_rdata : em_result_q;
                    mw_dest_d = em_dest_q;
                    mw_rw_d   = em_sig_q[SIG_RW];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capturing only when not stalled also makes flush a no-op during an access.
        if (!stall) begin
            em_result_d = ex_result;
            em_sdata_d  = ex_store_data;
            em_dest_d   = ex_reg_dest;
            em_sig_d    = in_vld ? ex_signals : 4'b0000;
            state_d     = in_mem ? ST_WAIT : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            em_result_q <= '0;
            em_sdata_q  <= '0;
            em_dest_q   <= '0;
            em_sig_q    <= '0;
            mw_op_q     <= '0;
            mw_dest_q   <= '0;
            mw_rw_q     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            em_result_q <= em_result_d;
            em_sdata_q  <= em_sdata_d;
            em_dest_q   <= em_dest_d;
            em_sig_q    <= em_sig_d;
            mw_op_q     <= mw_op_d;
            mw_dest_q   <= mw_dest_d;
            mw_rw_q     <= mw_rw_d;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    // Request fields come straight from EX/MEM, which is frozen while stalled.
    assign dmem_req   = (state_q == ST_WAIT);
    assign dmem_we    = dmem_req & em_sig_q[SIG_MW];
    assign dmem_addr  = dmem_req ? em_result_q : 32'h0;
    assign dmem_wdata = dmem_req ? em_sdata_q : 32'h0;

    assign EX_MEM_op       = em_result_q;
    assign EX_MEM_reg_dest = em_dest_q;
    assign EX_MEM_RegWrite = em_sig_q[SIG_RW];
    assign MEM_WB_op       = mw_op_q;
    assign MEM_WB_reg_dest = mw_dest_q;
    assign MEM_WB_RegWrite = mw_rw_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors, expected write-backs and memory requests queued at issue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_reg_dest;
    logic [3:0]  ex_signals;
    logic        flush;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic [31:0] EX_MEM_op;
    logic [4:0]  EX_MEM_reg_dest;
    logic        EX_MEM_RegWrite;
    logic [31:0] MEM_WB_op;
    logic [4:0]  MEM_WB_reg_dest;
    logic        MEM_WB_RegWrite;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_reg_dest(ex_reg_dest), .ex_signals(ex_signals),
        .flush(flush), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .EX_MEM_op(EX_MEM_op), .EX_MEM_reg_dest(EX_MEM_reg_dest),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_op(MEM_WB_op),
        .MEM_WB_reg_dest(MEM_WB_reg_dest), .MEM_WB_RegWrite(MEM_WB_RegWrite)
`ifdef MEM_ALIGN_CHECK_EN
        , .misaligned(misaligned)
`endif
    );

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] op;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  lat;
    } rq_t;

    wb_t wb_q[$];
    rq_t rq_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int stall_cycles = 0;
    int req_cycles = 0;
    int wb_writes = 0;
    int mis_cycles = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;
    logic force_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: answers each request after its queued latency and checks the request fields.
    int   req_cnt = 0;
    rq_t  cur;
    always @(negedge clk) begin
        if (rst) begin
            req_cnt  = 0;
            dmem_ack = force_ack;
        end else if (dmem_req) begin
            if (dmem_ack) req_cnt = 0;
            req_cnt++;
            req_cycles++;
            if (req_cnt == 1) begin
                if (rq_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got addr 0x%08h, expected no request", dmem_addr);
                    cur.we = dmem_we; cur.addr = dmem_addr; cur.wdata = dmem_wdata;
                    cur.rdata = 32'h0; cur.lat = 8'd1;
                end else begin
                    cur = rq_q.pop_front();
                    chk("req_we", {31'h0, dmem_we}, {31'h0, cur.we});
                    chk("req_addr", dmem_addr, cur.addr);
                    chk("req_wdata", dmem_wdata, cur.wdata);
                end
            end else begin
                chk("hold_we", {31'h0, dmem_we}, {31'h0, cur.we});
                chk("hold_addr", dmem_addr, cur.addr);
                chk("hold_wdata", dmem_wdata, cur.wdata);
            end
            dmem_ack   = (req_cnt >= int'(cur.lat));
            dmem_rdata = dmem_ack ? cur.rdata : 32'h0;
        end else begin
            req_cnt  = 0;
            dmem_ack = force_ack;
        end
    end

    // Monitor: every MEM/WB write must match the oldest expected write-back.
    wb_t got;
    always @(negedge clk) begin
        #1;
        if (stall) stall_cycles++;
`ifdef MEM_ALIGN_CHECK_EN
        if (misaligned) mis_cycles++;
`endif
        if (!rst && MEM_WB_RegWrite) begin
            wb_writes++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (wb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_wb: got dest %0d op 0x%08h, expected no write", MEM_WB_reg_dest, MEM_WB_op);
            end else begin
                got = wb_q.pop_front();
                chk("wb_op", MEM_WB_op, got.op);
                chk("wb_dest", {27'h0, MEM_WB_reg_dest}, {27'h0, got.dest});
            end
        end
    end

    task automatic issue(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] dest,
                         input logic [3:0] sig, input logic fl, input bit exp_wb,
                         input logic [31:0] exp_op, input bit exp_req, input logic exp_we,
                         input logic [7:0] lat, input logic [31:0] rd);
        rq_t r;
        wb_t w;
        bit  ok;
        if (exp_req) begin
            r.we = exp_we; r.addr = res; r.wdata = sd; r.rdata = rd; r.lat = lat;
            rq_q.push_back(r);
        end
        if (exp_wb) begin
            w.dest = dest; w.op = exp_op;
            wb_q.push_back(w);
        end
        ex_valid = 1'b1; ex_result = res; ex_store_data = sd;
        ex_reg_dest = dest; ex_signals = sig; flush = fl;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (!stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: stall still 1, expected 0 within 50 cycles");
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_signals = 4'h0; flush = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (wb_q.size() == 0 && rq_q.size() == 0 && !dmem_req) break;
        end
        chk(name, wb_q.size() + rq_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
        chk({tag, "_we"}, {31'h0, dmem_we}, 32'h0);
        chk({tag, "_addr"}, dmem_addr, 32'h0);
        chk({tag, "_wdata"}, dmem_wdata, 32'h0);
        chk({tag, "_em_op"}, EX_MEM_op, 32'h0);
        chk({tag, "_em_dest"}, {27'h0, EX_MEM_reg_dest}, 32'h0);
        chk({tag, "_em_rw"}, {31'h0, EX_MEM_RegWrite}, 32'h0);
        chk({tag, "_mw_op"}, MEM_WB_op, 32'h0);
        chk({tag, "_mw_dest"}, {27'h0, MEM_WB_reg_dest}, 32'h0);
        chk({tag, "_mw_rw"}, {31'h0, MEM_WB_RegWrite}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, "_mis"}, {31'h0, misaligned}, 32'h0);
`endif
    endtask

    int s0, r0, w0, m0;

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0;
        ex_reg_dest = '0; ex_signals = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        // ALU op: EX/MEM after E0, MEM/WB after E1.
        s0 = stall_cycles;
        issue(32'h10, 32'h0, 5'd5, 4'b1000, 1'b0, 1, 32'h10, 0, 1'b0, 8'd1, 32'h0);
        chk("alu_em_op", EX_MEM_op, 32'h10);
        chk("alu_em_dest", {27'h0, EX_MEM_reg_dest}, 32'd5);
        chk("alu_em_rw", {31'h0, EX_MEM_RegWrite}, 32'h1);
        @(posedge clk); #1;
        chk("alu_mw_op", MEM_WB_op, 32'h10);
        chk("alu_mw_dest", {27'h0, MEM_WB_reg_dest}, 32'd5);
        chk("alu_mw_rw", {31'h0, MEM_WB_RegWrite}, 32'h1);
        drain("alu_drain");
        chk("alu_stall", stall_cycles - s0, 32'd0);

        // Load with three request cycles.
        s0 = stall_cycles; r0 = req_cycles; w0 = wb_writes;
        issue(32'h100, 32'h0, 5'd7, 4'b1101, 1'b0, 1, 32'hDEADBEEF, 1, 1'b0, 8'd3, 32'hDEADBEEF);
        drain("ld_drain");
        chk("ld_req_cycles", req_cycles - r0, 32'd3);
        chk("ld_stall", stall_cycles - s0, 32'd2);
        chk("ld_writes", wb_writes - w0, 32'd1);

        // Store, zero-wait.
        s0 = stall_cycles; r0 = req_cycles; w0 = wb_writes;
        issue(32'h200, 32'h12345678, 5'd9, 4'b0010, 1'b0, 0, 32'h0, 1, 1'b1, 8'd1, 32'h0);
        drain("st_drain");
        chk("st_req_cycles", req_cycles - r0, 32'd1);
        chk("st_stall", stall_cycles - s0, 32'd0);
        chk("st_writes", wb_writes - w0, 32'd0);

        // Flushed load never reaches memory.
        r0 = req_cycles; w0 = wb_writes;
        issue(32'h104, 32'h0, 5'd3, 4'b1101, 1'b1, 0, 32'h0, 0, 1'b0, 8'd1, 32'h0);
        drain("fl_drain");
        chk("fl_req_cycles", req_cycles - r0, 32'd0);
        chk("fl_writes", wb_writes - w0, 32'd0);

        // Flush raised while the load is waiting.
        r0 = req_cycles; w0 = wb_writes;
        issue(32'h108, 32'h0, 5'd4, 4'b1101, 1'b0, 1, 32'hCAFEF00D, 1, 1'b0, 8'd3, 32'hCAFEF00D);
        flush = 1'b1;
        drain("flw_drain");
        flush = 1'b0;
        chk("flw_req_cycles", req_cycles - r0, 32'd3);
        chk("flw_writes", wb_writes - w0, 32'd1);

        // MemRead and MemWrite together is a write.
        s0 = stall_cycles; r0 = req_cycles;
        issue(32'h300, 32'hA5A5A5A5, 5'd6, 4'b0011, 1'b0, 0, 32'h0, 1, 1'b1, 8'd2, 32'h11111111);
        drain("rw_drain");
        chk("rw_req_cycles", req_cycles - r0, 32'd2);
        chk("rw_stall", stall_cycles - s0, 32'd1);

        // Back-to-back zero-wait loads: one write per cycle.
        s0 = stall_cycles; w0 = wb_writes;
        issue(32'h400, 32'h0, 5'd10, 4'b1101, 1'b0, 1, 32'h0A0A0A0A, 1, 1'b0, 8'd1, 32'h0A0A0A0A);
        issue(32'h404, 32'h0, 5'd11, 4'b1101, 1'b0, 1, 32'h0B0B0B0B, 1, 1'b0, 8'd1, 32'h0B0B0B0B);
        drain("b2b_drain");
        chk("b2b_stall", stall_cycles - s0, 32'd0);
        chk("b2b_writes", wb_writes - w0, 32'd2);
        chk("b2b_spacing", last_wr_cyc - prev_wr_cyc, 32'd1);

        // Reset in the second WAIT cycle, then a late ack.
        w0 = wb_writes;
        issue(32'h500, 32'h0, 5'd12, 4'b1101, 1'b0, 0, 32'h0, 1, 1'b0, 8'd6, 32'h77777777);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        force_ack = 1'b1;
        chk_reset("rstwait");
        repeat (3) @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("rstwait_req_after", {31'h0, dmem_req}, 32'h0);
        chk("rstwait_writes", wb_writes - w0, 32'd0);
        drain("rstwait_drain");

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned load is dropped with a one-cycle flag.
        r0 = req_cycles; w0 = wb_writes; m0 = mis_cycles;
        issue(32'h102, 32'h0, 5'd13, 4'b1101, 1'b0, 0, 32'h0, 0, 1'b0, 8'd1, 32'h0);
        drain("mis_drain");
        chk("mis_req_cycles", req_cycles - r0, 32'd0);
        chk("mis_writes", wb_writes - w0, 32'd0);
        chk("mis_pulse", mis_cycles - m0, 32'd1);
`else
        // Without the check, low address bits go out unchanged.
        r0 = req_cycles; w0 = wb_writes; m0 = mis_cycles;
        issue(32'h103, 32'h0, 5'd13, 4'b1101, 1'b0, 1, 32'h3C3C3C3C, 1, 1'b0, 8'd1, 32'h3C3C3C3C);
        drain("una_drain");
        chk("una_req_cycles", req_cycles - r0, 32'd1);
        chk("una_writes", wb_writes - w0, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
